// File: rtl/codec_volume_ctrl.sv
// Headphone volume/mute front end for the WM8731: debounces the up/down/mute keys
// and turns every change into one register write on the sequencer's manual port.
`timescale 1ns/1ps
module codec_volume_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         TIMEOUT_CYCLES  = 5000000,
    parameter logic [6:0] VOL_STEP        = 7'd4,
    parameter logic [6:0] VOL_MIN         = 7'h30,
    parameter logic [6:0] VOL_MAX         = 7'h7F,
    parameter logic [6:0] VOL_DEFAULT     = 7'h79
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       initDone,
    input  logic       keyUp_n,
    input  logic       keyDown_n,
    input  logic       keyMute_n,
    output logic       manualSend,
    output logic [6:0] manualRegister,
    output logic [8:0] manualData,
    input  logic       manualDone,
    output logic [6:0] volume,
    output logic       muted,
    output logic       busy,
    output logic       timeoutErr
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_INIT, SYNC, IDLE, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]    acc_q, acc_d, ev_q, ev_d;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];
    logic [6:0]    volume_q, volume_d;
    logic          muted_q, muted_d;
    logic          pend_vol_q, pend_vol_d, pend_mute_q, pend_mute_d;
    logic          send_q, send_d;
    logic [6:0]    reg_q, reg_d;
    logic [8:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          terr_q, terr_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic       issue_vol, issue_mute, tmo_hit;
    logic [7:0] vol_sum;
    logic [6:0] vol_up, vol_dn;

    // Key bits are {mute, down, up}; 1 means pressed.
    always_comb begin
        sync1_d = {~keyMute_n, ~keyDown_n, ~keyUp_n};
        sync2_d = sync1_q;
        acc_d   = acc_q;
        for (int k = 0; k < 3; k++) begin
            db_cnt_d[k] = '0;
            if (sync2_q[k] != acc_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    acc_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
        ev_d = acc_d & ~acc_q;
    end

    assign vol_sum = {1'b0, volume_q} + {1'b0, VOL_STEP};
    assign vol_up  = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : vol_sum[6:0];
    assign vol_dn  = ({1'b0, volume_q} < ({1'b0, VOL_MIN} + {1'b0, VOL_STEP}))
                     ? VOL_MIN : volume_q - VOL_STEP;
    assign tmo_hit = (tcnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_INIT: if (initDone) state_d = SYNC;
            SYNC:      state_d = WAIT_DONE;
            IDLE:      if (pend_mute_q || pend_vol_q) state_d = WAIT_DONE;
            WAIT_DONE: if (manualDone || tmo_hit) state_d = IDLE;
            default:   state_d = WAIT_INIT;
        endcase
    end

    // Handshake: manualSend is a one-cycle request with register/data valid in
    // the same cycle; the write is complete on the one-cycle manualDone pulse,
    // which is only honoured in WAIT_DONE.
    always_comb begin
        issue_mute = (state_q == IDLE) && pend_mute_q;
        issue_vol  = (state_q == SYNC) || ((state_q == IDLE) && !pend_mute_q && pend_vol_q);
        send_d     = issue_mute || issue_vol;
        reg_d      = reg_q;
        data_d     = data_q;
        if (issue_mute) begin
            reg_d  = 7'h05;
            data_d = muted_q ? 9'h008 : 9'h000;
        end else if (issue_vol) begin
            reg_d  = 7'h02;
            data_d = {1'b1, 1'b0, volume_q};
        end
        busy_d = (state_d != IDLE);
        terr_d = terr_q || ((state_q == WAIT_DONE) && !manualDone && tmo_hit);
        tcnt_d = '0;
        if (!send_d && (state_q == WAIT_DONE)) tcnt_d = tcnt_q + 1'b1;

        volume_d = volume_q;
        if (ev_q[0] && !ev_q[1]) volume_d = vol_up;
        if (ev_q[1] && !ev_q[0]) volume_d = vol_dn;
        muted_d = muted_q ^ ev_q[2];
        // A new event in the issue cycle re-arms the flag.
        pend_vol_d  = (pend_vol_q && !issue_vol) || (ev_q[0] ^ ev_q[1]);
        pend_mute_d = (pend_mute_q && !issue_mute) || ev_q[2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WAIT_INIT;
            sync1_q     <= '0;
            sync2_q     <= '0;
            acc_q       <= '0;
            ev_q        <= '0;
            for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
            volume_q    <= VOL_DEFAULT;
            muted_q     <= 1'b0;
            pend_vol_q  <= 1'b0;
            pend_mute_q <= 1'b0;
            send_q      <= 1'b0;
            reg_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b1;
            terr_q      <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            acc_q       <= acc_d;
            ev_q        <= ev_d;
            for (int k = 0; k < 3; k++) db_cnt_q[k] <= db_cnt_d[k];
            volume_q    <= volume_d;
            muted_q     <= muted_d;
            pend_vol_q  <= pend_vol_d;
            pend_mute_q <= pend_mute_d;
            send_q      <= send_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign manualSend     = send_q;
    assign manualRegister = reg_q;
    assign manualData     = data_q;
    assign volume         = volume_q;
    assign muted          = muted_q;
    assign busy           = busy_q;
    assign timeoutErr     = terr_q;
endmodule

// File: doc/codec_volume_ctrl.md
# codec_volume_ctrl

- User volume/mute front end for the WM8731 codec, sitting directly upstream of the codec init/I2C sequencer on its manual-write port.
- Debounces three DE2-115 push keys (up, down, mute) and holds the current headphone volume and mute state.
- Turns each change into a single register write using the manualSend/manualRegister/manualData/manualDone handshake, once codec initialisation has completed.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles before a key level is accepted (10 ms at 50 MHz).
- TIMEOUT_CYCLES, 5000000: maximum cycles to wait for manualDone.
- VOL_STEP, 4: volume increment/decrement per press.
- VOL_MIN, 7'h30: lowest code (WM8731 mute floor).
- VOL_MAX, 7'h7F: highest code (+6 dB).
- VOL_DEFAULT, 7'h79: code after reset (0 dB).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- initDone  in  1  high once the codec init sequence has finished; stays high.
- keyUp_n, keyDown_n, keyMute_n  in  1 each  raw keys, active-low, asynchronous.
- manualSend  out  1  one-cycle write request.
- manualRegister  out  7  codec register address.
- manualData  out  9  codec register data.
- manualDone  in  1  one-cycle pulse when the requested write has completed.
- volume  out  7  current volume code.
- muted  out  1  current mute state.
- busy  out  1  high whenever the state is not IDLE.
- timeoutErr  out  1  sticky; set on a handshake timeout; cleared only by rst.

## Operation
Key conditioning:
- Each key passes through a 2-FF synchroniser, then a per-key debouncer.
- A per-key counter runs while the synchronised level differs from the accepted level and resets when the two match. Width is $clog2(DEBOUNCE_CYCLES+1).
- When the counter reaches DEBOUNCE_CYCLES, the accepted level is updated.
- A press event is a one-cycle pulse on the accepted level's released-to-pressed transition. Releases produce no event.

Event handling (events are accepted in every state, including WAIT_INIT):
- Up: volume <= min(volume+VOL_STEP, VOL_MAX); set pendVol. Arithmetic is done in 8 bits, so there is no wrap.
- Down: volume <= max(volume-VOL_STEP, VOL_MIN); set pendVol.
- Up and down in the same cycle: no volume change, pendVol unchanged.
- Mute: muted <= ~muted; set pendMute. A mute event in the same cycle as up/down applies both.
- A press that lands on a limit still sets pendVol, so the write is re-issued.

Writes:
- Volume write: register 7'h02, data {1'b1 (LRHPBOTH), 1'b0, volume}.
- Mute write: register 7'h05, data 9'h008 if muted, 9'h000 if not.
- Data is sampled when the write is issued, so several changes made during a busy period collapse into one write.

State machine:
- WAIT_INIT (reset state): when initDone = 1 -> SYNC.
- SYNC: issue the volume write with the current volume, clear pendVol -> WAIT_DONE.
- IDLE:
  - pendMute -> issue the mute write, clear pendMute -> WAIT_DONE.
  - else pendVol -> issue the volume write, clear pendVol -> WAIT_DONE.
  - Mute has priority over volume.
- WAIT_DONE:
  - manualDone -> IDLE.
  - timeout counter reaches TIMEOUT_CYCLES -> set timeoutErr, IDLE. The pending flag stays cleared; a later event re-requests the write.
- If a pend flag is set in the same cycle the write for that flag is issued, the set wins, so the flag stays 1.

Reset values:
- manualSend 0, manualRegister 0, manualData 0.
- volume VOL_DEFAULT, muted 0, busy 1, timeoutErr 0.
- Pend flags 0, counters 0, accepted key levels released.
- Reset mid-transaction abandons the write immediately, with no further manualSend.

## Timing
- All outputs are registered.
- A press is held for the 2-cycle synchroniser plus DEBOUNCE_CYCLES, then produces an event at cycle E.
- volume/muted update at E+1.
- If the state is IDLE, manualSend = 1 at E+2 for exactly one cycle.
- manualRegister/manualData become valid with manualSend and hold until the next issue.
- manualDone at cycle D -> IDLE at D+1 -> the next pending write's manualSend at D+2. manualDone is never acted on outside WAIT_DONE.
- initDone rising at cycle I -> manualSend of the initial volume write at I+2.
- The timeout counter starts at the manualSend cycle.

## Test plan
All tests use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50, and a bench responder that pulses manualDone 20 cycles after each manualSend.
- Reset with initDone going high at cycle 10:
  - volume=7'h79, busy=1.
  - One write, reg 02 data 9'h179.
  - busy=0 after manualDone.
- Up press held 10 cycles:
  - volume 7'h7D, then write 9'h17D.
  - A second press gives 7'h7F (clamped); a third press gives 7'h7F with the write re-issued.
- Key glitch of 3 cycles -> no event, no manualSend.
- 40 down presses spaced 30 cycles apart -> volume saturates at 7'h30, never wraps.
- Mute and up pressed together while WAIT_DONE:
  - After the current write, the mute write (reg 05, 9'h008) is issued.
  - The volume write follows at D+2.
- Responder silent:
  - timeoutErr=1 at 50 cycles after manualSend.
  - Return to IDLE.
  - rst low mid-wait -> all outputs reach their reset values immediately.
